// File: rtl/wavetable_osc.sv
// Phase-accumulator wavetable oscillator with linear interpolation.
// One request walks IDLE -> RD_A -> RD_B -> INTERP -> OUT, reading two
// adjacent table entries through a single synchronous read port and
// presenting one interpolated signed sample with a one-cycle valid pulse.
module wavetable_osc #(
    parameter int SAMPLE_BITS = 16,
    parameter int TABLE_LEN   = 256,
    parameter int ADDR_BITS   = $clog2(TABLE_LEN),
    parameter int PHASE_BITS  = 32
) (
    input  logic                   mclk,
    input  logic                   rst_n,
    input  logic                   tbl_we,
    input  logic [ADDR_BITS-1:0]   tbl_waddr,
    input  logic [SAMPLE_BITS-1:0] tbl_wdata,
    input  logic [PHASE_BITS-1:0]  freq_word,
    input  logic                   enable,
    input  logic                   sample_req,
    output logic [SAMPLE_BITS-1:0] sample_out,
    output logic                   sample_valid,
    output logic                   busy,
    output logic                   overrun
);

    // Product width: (SAMPLE_BITS+1)-bit difference times 9-bit unsigned fraction.
    localparam int PW = SAMPLE_BITS + 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_A   = 3'd1,
        ST_RD_B   = 3'd2,
        ST_INTERP = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    logic [SAMPLE_BITS-1:0] mem_r [TABLE_LEN];
    logic [SAMPLE_BITS-1:0] rd_data_r;

    state_t                 state_r;
    logic [PHASE_BITS-1:0]  phase_r;
    logic [PHASE_BITS-1:0]  freq_r;
    logic                   en_r;
    logic [ADDR_BITS-1:0]   rd_addr_r;
    logic [7:0]             frac_r;
    logic [SAMPLE_BITS-1:0] a_r;
    logic [SAMPLE_BITS-1:0] sample_out_r;
    logic                   valid_r;
    logic                   busy_r;
    logic                   overrun_r;

    logic signed [SAMPLE_BITS:0] diff_s;
    logic signed [PW-1:0]        prod_s;
    logic [SAMPLE_BITS-1:0]      result_s;

    // Table RAM: write always honoured; the read returns the pre-write contents (read-first).
    always_ff @(posedge mclk) begin
        if (tbl_we) begin
            mem_r[tbl_waddr] <= tbl_wdata;
        end
        rd_data_r <= mem_r[rd_addr_r];
    end

    // Interpolation a + floor((b - a) * frac / 256); result lies between a and b so truncation is safe.
    always_comb begin
        diff_s   = $signed({rd_data_r[SAMPLE_BITS-1], rd_data_r}) - $signed({a_r[SAMPLE_BITS-1], a_r});
        prod_s   = PW'(diff_s) * PW'($signed({1'b0, frac_r}));
        result_s = SAMPLE_BITS'(PW'($signed(a_r)) + (prod_s >>> 8'd8));
    end

    // Sequencer: request latch, two table reads, interpolation, output and phase advance.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            phase_r      <= {PHASE_BITS{1'b0}};
            freq_r       <= {PHASE_BITS{1'b0}};
            en_r         <= 1'b0;
            rd_addr_r    <= {ADDR_BITS{1'b0}};
            frac_r       <= 8'd0;
            a_r          <= {SAMPLE_BITS{1'b0}};
            sample_out_r <= {SAMPLE_BITS{1'b0}};
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (sample_req && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (sample_req) begin
                        rd_addr_r <= phase_r[PHASE_BITS-1 -: ADDR_BITS];
                        frac_r    <= phase_r[PHASE_BITS-ADDR_BITS-1 -: 8];
                        freq_r    <= freq_word;
                        en_r      <= enable;
                        busy_r    <= 1'b1;
                        state_r   <= ST_RD_A;
                    end
                end
                ST_RD_A: begin
                    // Address wraps naturally at the power-of-two table length.
                    rd_addr_r <= rd_addr_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                    state_r   <= ST_RD_B;
                end
                ST_RD_B: begin
                    a_r     <= rd_data_r;
                    state_r <= ST_INTERP;
                end
                ST_INTERP: begin
                    sample_out_r <= en_r ? result_s : {SAMPLE_BITS{1'b0}};
                    valid_r      <= 1'b1;
                    state_r      <= ST_OUT;
                end
                ST_OUT: begin
                    phase_r <= en_r ? (phase_r + freq_r) : {PHASE_BITS{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign sample_out   = sample_out_r;
    assign sample_valid = valid_r;
    assign busy         = busy_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_wavetable_osc.sv
// Directed bench for wavetable_osc: expected samples and their request
// cycles are queued at request time and popped when sample_valid pulses.
module tb_wavetable_osc;

    logic        mclk = 1'b0;
    logic        rst_n;
    logic        tbl_we;
    logic [7:0]  tbl_waddr;
    logic [15:0] tbl_wdata;
    logic [31:0] freq_word;
    logic        enable;
    logic        sample_req;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic        overrun;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   exp_q[$];
    int   cyc_q[$];
    logic prev_valid = 1'b0;

    always #5 mclk = ~mclk;

    wavetable_osc dut (
        .mclk         (mclk),
        .rst_n        (rst_n),
        .tbl_we       (tbl_we),
        .tbl_waddr    (tbl_waddr),
        .tbl_wdata    (tbl_wdata),
        .freq_word    (freq_word),
        .enable       (enable),
        .sample_req   (sample_req),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one cycle, then compare any produced sample against the scoreboard.
    task automatic tick();
        int e;
        int c;
        @(posedge mclk);
        #1;
        cyc++;
        if (sample_valid === 1'b1) begin
            check("valid_gap", prev_valid, 0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                check("sample", $signed(sample_out), e);
                check("latency", cyc - c, 4);
            end else begin
                check("spurious_valid", sample_valid, 0);
            end
        end
        prev_valid = sample_valid;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        tbl_we    = 1'b1;
        tbl_waddr = a;
        tbl_wdata = d;
        tick();
        tbl_we    = 1'b0;
    endtask

    task automatic req(input int exp);
        sample_req = 1'b1;
        exp_q.push_back(exp);
        cyc_q.push_back(cyc);
        tick();
        sample_req = 1'b0;
        check("busy_after_req", busy, 1);
    endtask

    task automatic req_wait(input int exp);
        req(exp);
        repeat (31) tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        tbl_we     = 1'b0;
        tbl_waddr  = 8'd0;
        tbl_wdata  = 16'd0;
        freq_word  = 32'd0;
        enable     = 1'b0;
        sample_req = 1'b0;
        repeat (2) tick();

        // Reset state and request ignored while in reset
        check("rst_sample_out", $signed(sample_out), 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst_valid", sample_valid, 0);
            check("rst_busy_hold", busy, 0);
        end

        // Ramp table[k] = k*64
        for (int k = 0; k < 256; k++) begin
            wr(8'(k), 16'(k * 64));
        end
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // Integer-step phase
        enable    = 1'b1;
        freq_word = 32'h0100_0000;
        for (int k = 0; k < 4; k++) begin
            req_wait(k * 64);
        end

        // Half-step phase from zero: frac alternates 0/128
        enable = 1'b0;
        req_wait(0);
        enable    = 1'b1;
        freq_word = 32'h0080_0000;
        for (int k = 0; k < 4; k++) begin
            req_wait(k * 32);
        end

        // Index wrap 255 -> 0 with frac 128
        wr(8'd255, 16'd1000);
        wr(8'd0, 16'd0);
        enable = 1'b0;
        req_wait(0);
        enable    = 1'b1;
        freq_word = 32'hFF80_0000;
        req_wait(0);
        freq_word = 32'd0;
        req_wait(500);

        // Negative difference floors toward -inf
        wr(8'd10, -16'sd100);
        wr(8'd11, -16'sd101);
        enable = 1'b0;
        req_wait(0);
        enable    = 1'b1;
        freq_word = 32'h0A80_0000;
        req_wait(0);
        freq_word = 32'd0;
        req_wait(-101);

        // a=100, b=-3, frac=64: 100 + floor(-103*64/256) = 74
        wr(8'd20, 16'sd100);
        wr(8'd21, -16'sd3);
        enable = 1'b0;
        req_wait(0);
        enable    = 1'b1;
        freq_word = 32'h1440_0000;
        req_wait(0);
        freq_word = 32'd0;
        req_wait(74);

        // Overrun: second request two cycles later, and one in the OUT cycle
        check("overrun_clear", overrun, 0);
        req(74);
        tick();
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        check("overrun_set", overrun, 1);
        tick();
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        check("busy_after_out", busy, 0);
        repeat (10) tick();
        check("overrun_sticky", overrun, 1);

        // Mute with nonzero phase, then phase restarts at table[0]
        wr(8'd0, 16'sd777);
        enable = 1'b0;
        req_wait(0);
        enable = 1'b1;
        req_wait(777);
        check("overrun_still", overrun, 1);

        // Async reset during RD_B aborts the sample
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        tick();
        check("busy_rd_b", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_sample_out", $signed(sample_out), 0);
        check("abort_valid", sample_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_overrun", overrun, 0);
        repeat (4) tick();
        rst_n = 1'b1;
        tick();
        req_wait(777);

        check("pending", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
